// File: rtl/load_store_unit_pkg.sv
// Shared width codes, FSM states and access-legality helper for the load/store unit.
package load_store_unit_pkg;

  typedef enum logic [1:0] {
    LSU_IDLE = 2'd0,
    LSU_REQ  = 2'd1,
    LSU_DONE = 2'd2
  } lsu_state_e;

  localparam logic [2:0] LSU_B  = 3'b000;
  localparam logic [2:0] LSU_H  = 3'b001;
  localparam logic [2:0] LSU_W  = 3'b010;
  localparam logic [2:0] LSU_BU = 3'b100;
  localparam logic [2:0] LSU_HU = 3'b101;

  // Illegal width codes are folded into the misaligned rejection path.
  function automatic logic lsu_misaligned(input logic       we,
                                          input logic [2:0] funct3,
                                          input logic [1:0] addr_lo);
    logic bad;
    case (funct3)
      LSU_B:   bad = 1'b0;
      LSU_BU:  bad = we;
      LSU_H:   bad = addr_lo[0];
      LSU_HU:  bad = we | addr_lo[0];
      LSU_W:   bad = |addr_lo;
      default: bad = 1'b1;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/load_store_unit_load_extend.sv
// Selects the addressed byte/halfword of a read word and sign- or zero-extends it.
module load_extend
  import load_store_unit_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [2:0]  funct3,
  input  logic [1:0]  addr_lo,
  output logic [31:0] result
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = rdata[8*addr_lo +: 8];
    half_sel = addr_lo[1] ? rdata[31:16] : rdata[15:0];
    case (funct3)
      LSU_B:   result = {{24{byte_sel[7]}}, byte_sel};
      LSU_BU:  result = {24'd0, byte_sel};
      LSU_H:   result = {{16{half_sel[15]}}, half_sel};
      LSU_HU:  result = {16'd0, half_sel};
      default: result = rdata;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Memory-side data path: one load/store per request, registered bus outputs,
// variable-latency ready handshake, extended load result held in data_buf.
module load_store_unit
  import load_store_unit_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  input  logic                  req_we,
  input  logic [2:0]            req_funct3,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [31:0]           req_wdata,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [31:0]           mem_wdata,
  output logic [3:0]            mem_wstrb,
  input  logic                  mem_ready,
  input  logic [31:0]           mem_rdata,
  output logic [31:0]           data_buf,
  output logic                  busy,
  output logic                  done,
  output logic                  misaligned
);

  lsu_state_e            state_q, state_d;
  logic                  we_q, we_d;
  logic [2:0]            funct3_q, funct3_d;
  logic [1:0]            lane_q, lane_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [31:0]           wdata_q, wdata_d;
  logic [3:0]            wstrb_q, wstrb_d;
  logic                  mis_q, mis_d;
  logic [31:0]           data_buf_q, data_buf_d;

  logic                  req_mis;
  logic [31:0]           st_wdata;
  logic [3:0]            st_wstrb;
  logic [31:0]           ld_ext;

  load_extend u_load_extend (
    .rdata   (mem_rdata),
    .funct3  (funct3_q),
    .addr_lo (lane_q),
    .result  (ld_ext)
  );

  always_comb begin
    req_mis = lsu_misaligned(req_we, req_funct3, req_addr[1:0]);
    case (req_funct3[1:0])
      2'b00: begin
        st_wdata = {4{req_wdata[7:0]}};
        st_wstrb = 4'b0001 << req_addr[1:0];
      end
      2'b01: begin
        st_wdata = {2{req_wdata[15:0]}};
        st_wstrb = req_addr[1] ? 4'b1100 : 4'b0011;
      end
      default: begin
        st_wdata = req_wdata;
        st_wstrb = 4'b1111;
      end
    endcase
  end

  always_comb begin
    state_d    = state_q;
    we_d       = we_q;
    funct3_d   = funct3_q;
    lane_d     = lane_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    wstrb_d    = wstrb_q;
    mis_d      = mis_q;
    data_buf_d = data_buf_q;
    unique case (state_q)
      LSU_IDLE: begin
        if (req_valid) begin
          // Rejected accesses latch no write intent so the bus stays quiet.
          we_d     = req_we & ~req_mis;
          funct3_d = req_funct3;
          lane_d   = req_addr[1:0];
          addr_d   = {req_addr[ADDR_WIDTH-1:2], 2'b00};
          wdata_d  = st_wdata;
          wstrb_d  = (req_we && !req_mis) ? st_wstrb : '0;
          mis_d    = req_mis;
          state_d  = req_mis ? LSU_DONE : LSU_REQ;
        end
      end
      LSU_REQ: begin
        if (mem_ready) begin
          if (!we_q) data_buf_d = ld_ext;
          state_d = LSU_DONE;
        end
      end
      LSU_DONE: state_d = LSU_IDLE;
      default:  state_d = LSU_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= LSU_IDLE;
      we_q       <= 1'b0;
      funct3_q   <= '0;
      lane_q     <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      wstrb_q    <= '0;
      mis_q      <= 1'b0;
      data_buf_q <= '0;
    end else begin
      state_q    <= state_d;
      we_q       <= we_d;
      funct3_q   <= funct3_d;
      lane_q     <= lane_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      wstrb_q    <= wstrb_d;
      mis_q      <= mis_d;
      data_buf_q <= data_buf_d;
    end
  end

  assign mem_req    = (state_q == LSU_REQ);
  assign mem_we     = we_q;
  assign mem_addr   = addr_q;
  assign mem_wdata  = wdata_q;
  assign mem_wstrb  = wstrb_q;
  assign data_buf   = data_buf_q;
  assign busy       = (state_q != LSU_IDLE);
  assign done       = (state_q == LSU_DONE);
  assign misaligned = (state_q == LSU_DONE) & mis_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit: random and directed accesses against a byte-level reference model.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr, req_wdata;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        mem_ready;
  logic [31:0] mem_rdata;
  logic [31:0] data_buf;
  logic        busy, done, misaligned;

  always #5 clk = ~clk;

  load_store_unit #(.ADDR_WIDTH(32)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_we     (req_we),
    .req_funct3 (req_funct3),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_wstrb  (mem_wstrb),
    .mem_ready  (mem_ready),
    .mem_rdata  (mem_rdata),
    .data_buf   (data_buf),
    .busy       (busy),
    .done       (done),
    .misaligned (misaligned)
  );

  typedef struct {
    logic        we;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    int          waits;
  } txn_t;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
  } bus_exp_t;

  typedef struct {
    logic        mis;
    logic [31:0] buf_val;
  } done_exp_t;

  bus_exp_t  bus_q[$];
  done_exp_t done_q[$];
  int        checks = 0;
  int        errors = 0;
  logic [31:0] model_buf = '0;
  int        cur_waits = 0;
  logic [31:0] cur_rdata = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int size_bytes(input logic [2:0] f3);
    return 1 << f3[1:0];
  endfunction

  function automatic logic model_mis(input logic we, input logic [2:0] f3, input logic [31:0] a);
    logic legal;
    legal = we ? (f3 inside {3'd0, 3'd1, 3'd2}) : (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
    if (!legal) return 1'b1;
    return (a % size_bytes(f3)) != 0;
  endfunction

  function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] rd);
    int          nb, bits;
    logic [31:0] v, mask;
    nb   = size_bytes(f3);
    bits = 8 * nb;
    v    = rd >> (8 * (a % 4));
    if (bits < 32) begin
      mask = (32'd1 << bits) - 32'd1;
      v    = v & mask;
      if (!f3[2] && v[bits-1]) v = v | ~mask;
    end
    return v;
  endfunction

  // Memory responder: ready after the transaction's wait count, junk otherwise.
  initial begin
    int cnt;
    cnt = 0;
    mem_ready = 1'b0;
    mem_rdata = '0;
    forever begin
      @(negedge clk);
      if (mem_req) begin
        if (cnt == cur_waits) begin
          mem_ready = 1'b1;
          mem_rdata = cur_rdata;
        end else begin
          mem_ready = 1'b0;
          mem_rdata = $urandom;
        end
        cnt++;
      end else begin
        cnt = 0;
        mem_ready = 1'($urandom % 2);
        mem_rdata = $urandom;
      end
    end
  end

  // Monitor: bus and completion checks, decoupled from the driver.
  initial begin
    bus_exp_t  be;
    done_exp_t de;
    forever begin
      @(negedge clk);
      #1;
      if (!rst) begin
        if (mem_req) begin
          if (bus_q.size() == 0) begin
            chk("unexpected_mem_req", 32'(mem_req), 32'd0);
          end else begin
            be = bus_q[0];
            chk("mem_addr", mem_addr, be.addr);
            chk("mem_we", 32'(mem_we), 32'(be.we));
            chk("mem_wstrb", 32'(mem_wstrb), 32'(be.wstrb));
            if (be.we) chk("mem_wdata", mem_wdata, be.wdata);
            if (mem_ready) void'(bus_q.pop_front());
          end
        end
        if (done) begin
          if (done_q.size() == 0) begin
            chk("unexpected_done", 32'(done), 32'd0);
          end else begin
            de = done_q.pop_front();
            chk("misaligned", 32'(misaligned), 32'(de.mis));
            chk("data_buf", data_buf, de.buf_val);
          end
        end else if (misaligned) begin
          chk("misaligned_without_done", 32'(misaligned), 32'd0);
        end
      end
    end
  end

  task automatic issue(input txn_t t);
    logic      mis;
    bus_exp_t  be;
    done_exp_t de;
    int        n, nb, off;
    mis = model_mis(t.we, t.f3, t.addr);
    if (!mis) begin
      nb  = size_bytes(t.f3);
      off = int'(t.addr % 4);
      be.we    = t.we;
      be.addr  = t.addr & ~32'd3;
      be.wdata = '0;
      be.wstrb = '0;
      for (int i = 0; i < 4; i++) begin
        be.wdata[8*i +: 8] = t.wdata[8*(i % nb) +: 8];
        if (t.we && i >= off && i < off + nb) be.wstrb[i] = 1'b1;
      end
      bus_q.push_back(be);
      if (!t.we) model_buf = model_load(t.f3, t.addr, t.rdata);
    end
    de.mis     = mis;
    de.buf_val = model_buf;
    done_q.push_back(de);
    cur_waits  = t.waits;
    cur_rdata  = t.rdata;
    req_valid  = 1'b1;
    req_we     = t.we;
    req_funct3 = t.f3;
    req_addr   = t.addr;
    req_wdata  = t.wdata;
    n = 0;
    @(negedge clk);
    while (busy && n < 64) begin
      n++;
      req_valid  = 1'($urandom % 2);
      req_we     = 1'($urandom % 2);
      req_funct3 = 3'($urandom % 8);
      req_addr   = $urandom;
      req_wdata  = $urandom;
      @(negedge clk);
    end
    req_valid = 1'b0;
    chk("busy_cycles", 32'(n), mis ? 32'd1 : 32'(t.waits + 2));
  endtask

  txn_t dir[$];

  initial begin
    txn_t t;
    rst = 1'b1;
    req_valid = 1'b0; req_we = 1'b0; req_funct3 = '0; req_addr = '0; req_wdata = '0;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_mem_req", 32'(mem_req), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'({done, misaligned}), 32'd0);
    chk("rst_mem_we_wstrb", 32'({mem_we, mem_wstrb}), 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    chk("rst_mem_wdata", mem_wdata, 32'd0);
    chk("rst_data_buf", data_buf, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    dir.push_back('{1'b0, 3'b010, 32'h100, 32'h0,        32'hDEADBEEF, 2});
    dir.push_back('{1'b0, 3'b000, 32'h103, 32'h0,        32'h80FF1234, 0});
    dir.push_back('{1'b0, 3'b100, 32'h103, 32'h0,        32'h80FF1234, 1});
    dir.push_back('{1'b0, 3'b001, 32'h102, 32'h0,        32'h80FF1234, 0});
    dir.push_back('{1'b1, 3'b000, 32'h201, 32'h000000A5, 32'h0,        0});
    dir.push_back('{1'b1, 3'b001, 32'h202, 32'h0000BEEF, 32'h0,        1});
    dir.push_back('{1'b0, 3'b010, 32'h102, 32'h0,        32'h11111111, 0});
    dir.push_back('{1'b1, 3'b001, 32'h301, 32'h1234,     32'h0,        0});
    dir.push_back('{1'b1, 3'b010, 32'h300, 32'h12345678, 32'h0,        0});
    dir.push_back('{1'b0, 3'b101, 32'h102, 32'h0,        32'h80FF1234, 0});
    dir.push_back('{1'b0, 3'b011, 32'h400, 32'h0,        32'h0,        0});
    dir.push_back('{1'b1, 3'b100, 32'h400, 32'h55,       32'h0,        0});
    foreach (dir[i]) issue(dir[i]);

    for (int i = 0; i < 300; i++) begin
      t.we    = 1'($urandom % 2);
      t.f3    = 3'($urandom % 8);
      t.addr  = $urandom;
      t.wdata = $urandom;
      t.rdata = $urandom;
      t.waits = ($urandom % 3 == 0) ? int'($urandom % 4) : 0;
      issue(t);
    end

    // Reset in the middle of a stalled load: no completion, buffers cleared.
    t = '{1'b0, 3'b010, 32'h500, 32'h0, 32'hCAFEF00D, 20};
    cur_waits = 20;
    cur_rdata = t.rdata;
    bus_q.push_back('{1'b0, 32'h500, 32'h0, 4'h0});
    req_valid = 1'b1; req_we = 1'b0; req_funct3 = t.f3; req_addr = t.addr;
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    bus_q.delete();
    done_q.delete();
    model_buf = '0;
    #1;
    chk("rstreq_mem_req", 32'(mem_req), 32'd0);
    chk("rstreq_busy", 32'(busy), 32'd0);
    chk("rstreq_done", 32'(done), 32'd0);
    chk("rstreq_data_buf", data_buf, 32'd0);
    repeat (3) @(negedge clk);
    issue('{1'b0, 3'b010, 32'h600, 32'h0, 32'h0BADCAFE, 1});
    issue('{1'b0, 3'b000, 32'h601, 32'h0, 32'h0000F700, 0});
    repeat (3) @(negedge clk);
    chk("bus_queue_drained", 32'(bus_q.size()), 32'd0);
    chk("done_queue_drained", 32'(done_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
